// File: rtl/pe_with_maxpool.sv
// 3x3 convolution PE with channel accumulation and fused 2-wide max-pooling.
// Takes one image column per clock and emits one pooled 16-bit value per pair of columns.
module pe_with_maxpool #(
    parameter int IMG_ROW    = 13,
    parameter int WEIGHT_ROW = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IMG_ROW-1:0]      start,
    input  logic [2:0]              channel_packed,
    input  logic [IMG_ROW*8-1:0]    img,
    input  logic [WEIGHT_ROW*8-1:0] weight_top,
    input  logic [WEIGHT_ROW*8-1:0] weight_mid,
    input  logic [WEIGHT_ROW*8-1:0] weight_bottom,
    output logic [15:0]             out_value
);

    localparam int OUT_ROWS = IMG_ROW - 2;
    localparam int DEPTH    = 8;

    logic [IMG_ROW*8-1:0] delay_reg [DEPTH];
    logic [IMG_ROW*8-1:0] col_tap   [3];
    logic [7:0]           w         [3][WEIGHT_ROW];
    logic [15:0]          sat       [OUT_ROWS];

    logic [1:0]  phase_reg;
    logic [1:0]  col_reg;
    logic        odd_reg;
    logic [15:0] hold_reg;
    logic [15:0] out_reg;

    logic [1:0]  last_idx;
    logic [2:0]  mid_idx;
    logic [2:0]  far_idx;
    logic        first_phase;
    logic        last_phase;
    logic [15:0] col_max;

    // The top two start bits have no conv row behind them.
    logic unused_start;
    assign unused_start = ^start[IMG_ROW-1:IMG_ROW-2];

    // Taps sit C and 2C columns back; unknown encodings fall back to a single channel.
    always_comb begin
        last_idx = 2'd0;
        mid_idx  = 3'd0;
        far_idx  = 3'd1;
        case (channel_packed)
            3'b010: begin
                last_idx = 2'd1;
                mid_idx  = 3'd1;
                far_idx  = 3'd3;
            end
            3'b100: begin
                last_idx = 2'd3;
                mid_idx  = 3'd3;
                far_idx  = 3'd7;
            end
            default: begin
                last_idx = 2'd0;
                mid_idx  = 3'd0;
                far_idx  = 3'd1;
            end
        endcase
    end

    // ">=" rather than "==" so a mid-stream change of C can never strand the phase counter.
    assign first_phase = (phase_reg == 2'd0);
    assign last_phase  = (phase_reg >= last_idx);

    assign col_tap[0] = delay_reg[far_idx];
    assign col_tap[1] = delay_reg[mid_idx];
    assign col_tap[2] = img;

    generate
        for (genvar gi = 0; gi < WEIGHT_ROW; gi++) begin : g_weight
            assign w[0][gi] = weight_top[8*gi +: 8];
            assign w[1][gi] = weight_mid[8*gi +: 8];
            assign w[2][gi] = weight_bottom[8*gi +: 8];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < OUT_ROWS; gi++) begin : g_row
            logic [19:0] conv;
            logic [15:0] prod;
            logic [22:0] done_val;
            logic [22:0] row_val;
            logic [22:0] acc_reg;

            always_comb begin
                conv = '0;
                prod = '0;
                for (int t = 0; t < 3; t++) begin
                    for (int j = 0; j < WEIGHT_ROW; j++) begin
                        prod = col_tap[j][8*(gi+t) +: 8] * w[t][j];
                        conv = conv + 20'(prod);
                    end
                end
            end

            assign done_val = (first_phase ? 23'd0 : acc_reg) + 23'(conv);
            assign row_val  = start[gi] ? done_val : 23'd0;
            assign sat[gi]  = (|row_val[22:16]) ? 16'hFFFF : row_val[15:0];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_reg <= '0;
                end else begin
                    acc_reg <= row_val;
                end
            end
        end
    endgenerate

    always_comb begin
        col_max = '0;
        for (int r = 0; r < OUT_ROWS; r++) begin
            if (sat[r] > col_max) begin
                col_max = sat[r];
            end
        end
    end

    // col_reg saturates at 2 ("window full"); pair parity is tracked separately by odd_reg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                delay_reg[i] <= '0;
            end
            phase_reg <= '0;
            col_reg   <= '0;
            odd_reg   <= 1'b0;
            hold_reg  <= '0;
            out_reg   <= '0;
        end else begin
            delay_reg[0] <= img;
            for (int i = 1; i < DEPTH; i++) begin
                delay_reg[i] <= delay_reg[i-1];
            end
            if (last_phase) begin
                phase_reg <= '0;
                odd_reg   <= ~odd_reg;
                if (col_reg != 2'd2) begin
                    col_reg <= col_reg + 2'd1;
                end else if (odd_reg) begin
                    out_reg <= (hold_reg > col_max) ? hold_reg : col_max;
                end else begin
                    hold_reg <= col_max;
                end
            end else begin
                phase_reg <= phase_reg + 2'd1;
            end
        end
    end

    assign out_value = out_reg;

endmodule

// File: tb/tb_pe_with_maxpool.sv
// Bench for pe_with_maxpool: directed and random streams compared cycle by cycle
// against a column-window reference model of the pooled output.
module tb_pe_with_maxpool;

    localparam int IMG_ROW = 13;
    localparam int MAXN    = 256;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [IMG_ROW-1:0]   start = '0;
    logic [2:0]           channel_packed = 3'b001;
    logic [IMG_ROW*8-1:0] img = '0;
    logic [23:0]          weight_top = '0;
    logic [23:0]          weight_mid = '0;
    logic [23:0]          weight_bottom = '0;
    logic [15:0]          out_value;

    int checks   = 0;
    int failures = 0;
    int run_id   = 0;

    int img_h [MAXN][IMG_ROW];
    int w_h   [MAXN][3][3];
    int m_hold = 0;
    int m_out  = 0;

    pe_with_maxpool #(.IMG_ROW(IMG_ROW), .WEIGHT_ROW(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .channel_packed (channel_packed),
        .img            (img),
        .weight_top     (weight_top),
        .weight_mid     (weight_mid),
        .weight_bottom  (weight_bottom),
        .out_value      (out_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Asynchronous clear mid-cycle, hold through two edges, release at a falling edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", {16'd0, out_value}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", {16'd0, out_value}, 32'd0);
        end
        @(negedge clk);
        reset  = 1'b1;
        m_hold = 0;
        m_out  = 0;
    endtask

    // mode 0: constant pv/wv; 1: img byte i = i+1, weights 1;
    // 2: img 1 except column 2 = 2, weights 1; 3: random img<=pv, weights<=wv.
    task automatic run(input logic [2:0] code, input int mode, input int pv, input int wv,
                       input logic [IMG_ROW-1:0] st, input int ncyc, input int final_exp);
        int c;
        run_id++;
        case (code)
            3'b010:  c = 2;
            3'b100:  c = 4;
            default: c = 1;
        endcase
        channel_packed = code;
        start          = st;
        for (int n = 0; n < ncyc; n++) begin
            int k;
            int p;
            k = n / c;
            p = n % c;
            for (int i = 0; i < IMG_ROW; i++) begin
                case (mode)
                    0:       img_h[n][i] = pv;
                    1:       img_h[n][i] = i + 1;
                    2:       img_h[n][i] = (k == 2) ? 2 : 1;
                    default: img_h[n][i] = int'($urandom_range(0, pv));
                endcase
                img[8*i +: 8] = 8'(img_h[n][i]);
            end
            for (int t = 0; t < 3; t++) begin
                for (int j = 0; j < 3; j++) begin
                    case (mode)
                        0:       w_h[n][t][j] = wv;
                        3:       w_h[n][t][j] = int'($urandom_range(0, wv));
                        default: w_h[n][t][j] = 1;
                    endcase
                end
            end
            for (int j = 0; j < 3; j++) begin
                weight_top[8*j +: 8]    = 8'(w_h[n][0][j]);
                weight_mid[8*j +: 8]    = 8'(w_h[n][1][j]);
                weight_bottom[8*j +: 8] = 8'(w_h[n][2][j]);
            end
            @(posedge clk);
            #1;
            // Column k is complete: sum every channel of its 3x3 windows, saturate, pool.
            if (p == c - 1 && k >= 2) begin
                int mx;
                mx = 0;
                for (int r = 0; r < IMG_ROW - 2; r++) begin
                    int sum;
                    sum = 0;
                    if (st[r]) begin
                        for (int q = 0; q < c; q++) begin
                            int m;
                            m = k * c + q;
                            for (int t = 0; t < 3; t++) begin
                                for (int j = 0; j < 3; j++) begin
                                    sum += img_h[m - (2 - j) * c][r + t] * w_h[m][t][j];
                                end
                            end
                        end
                        if (sum > 65535) sum = 65535;
                    end
                    if (sum > mx) mx = sum;
                end
                if (k % 2 == 0) m_hold = mx;
                else m_out = (m_hold > mx) ? m_hold : mx;
            end
            check($sformatf("run%0d_cycle%0d", run_id, n), {16'd0, out_value}, 32'(m_out));
            @(negedge clk);
        end
        if (final_exp >= 0) begin
            check($sformatf("run%0d_final", run_id), {16'd0, out_value}, 32'(final_exp));
        end
        $display("run %0d: C code=%b mode=%0d cycles=%0d out_value=%0d model=%0d",
                 run_id, code, mode, ncyc, out_value, m_out);
    endtask

    initial begin
        #1;
        check("reset_at_time0", {16'd0, out_value}, 32'd0);
        @(negedge clk);
        do_reset();
        run(3'b001, 0, 1, 1, '1, 12, 9);
        do_reset();
        run(3'b010, 0, 1, 1, '1, 20, 18);
        do_reset();
        run(3'b100, 0, 255, 255, '1, 24, 65535);
        do_reset();
        run(3'b001, 1, 0, 0, '1, 10, 108);
        do_reset();
        run(3'b001, 1, 0, 0, 13'h1BFF, 10, 99);
        do_reset();
        run(3'b001, 1, 0, 0, '0, 10, 0);
        do_reset();
        run(3'b011, 1, 0, 0, '1, 10, 108);
        do_reset();
        run(3'b001, 2, 0, 0, '1, 12, -1);
        do_reset();
        run(3'b001, 0, 1, 1, '1, 12, 9);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] code;
            case ($urandom_range(0, 3))
                0:       code = 3'b001;
                1:       code = 3'b010;
                2:       code = 3'b100;
                default: code = 3'b000;
            endcase
            do_reset();
            run(code, 3, 40, 40, IMG_ROW'($urandom), 40, -1);
        end
        do_reset();
        run(3'b010, 3, 255, 255, '1, 30, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
